// File: rtl/open_drain_loopback_tester_pkg.sv
// Shared state encoding and sizing helpers for the open-drain loopback tester.
package open_drain_loopback_tester_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SETTLE = 3'd1,
        TALK   = 3'd2,
        TAIL   = 3'd3,
        CHECK  = 3'd4,
        NEXT   = 3'd5
    } state_e;

    // Edge counters must hold PULSE_COUNT+1 so an extra edge is distinguishable.
    function automatic int cnt_width(input int pulse_count);
        return $clog2(pulse_count + 2);
    endfunction

    function automatic int talker_width(input int num_pins);
        return (num_pins > 1) ? $clog2(num_pins) : 1;
    endfunction

endpackage

// File: rtl/open_drain_loopback_tester_if.sv
// Control/status bundle of the loopback tester; the pads stay a separate inout.
interface open_drain_loopback_tester_if #(
    parameter int NUM_PINS = 2
);
    import open_drain_loopback_tester_pkg::*;

    localparam int TW = talker_width(NUM_PINS);

    // start_i is a one-cycle request accepted only while busy_o=0; busy_o rises the
    // cycle after acceptance and falls together with done_o rising at end of run.
    logic                start_i;
    logic                busy_o;
    logic                done_o;
    logic [TW-1:0]       talker_o;
    logic [NUM_PINS-1:0] pass_mask_o;
    logic [NUM_PINS-1:0] led_recv_o;
    state_e              state_o;

    modport master (
        output start_i,
        input  busy_o, done_o, talker_o, pass_mask_o, led_recv_o, state_o
    );

    modport slave (
        input  start_i,
        output busy_o, done_o, talker_o, pass_mask_o, led_recv_o, state_o
    );

endinterface

// File: rtl/open_drain_loopback_tester_pin_channel.sv
// One open-drain pad: pull-low driver, input synchroniser, rising-edge detect and a
// saturating edge counter.
module open_drain_loopback_tester_pin_channel
    import open_drain_loopback_tester_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int PULSE_COUNT = 5,
    parameter int CW          = cnt_width(PULSE_COUNT)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          drive_low_i,
    input  logic          clr_i,
    input  logic          cnt_en_i,
    inout  wire           pad_io,
    output logic          level_o,
    output logic [CW-1:0] count_o
);

    localparam logic [CW-1:0] SAT = CW'(PULSE_COUNT + 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic                   rise;

    // Never drive a 1: the net's high level comes only from the pull-up.
    assign pad_io  = drive_low_i ? 1'b0 : 1'bz;
    assign level_o = sync_q[SYNC_STAGES-1];
    assign rise    = level_o & ~prev_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q  <= '1;
            prev_q  <= 1'b1;
            count_o <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pad_io};
            prev_q <= level_o;
            if (clr_i) begin
                count_o <= '0;
            end else if (cnt_en_i && rise && (count_o != SAT)) begin
                count_o <= count_o + CW'(1);
            end
        end
    end

endmodule

// File: rtl/open_drain_loopback_tester.sv
// Loopback exerciser: each pin in turn pulses the shared net low while all pins
// count released edges; a per-talker pass mask summarises the run.
module open_drain_loopback_tester
    import open_drain_loopback_tester_pkg::*;
#(
    parameter int NUM_PINS      = 2,
    parameter int TICK_INTERVAL = 27000000,
    parameter int PULSE_COUNT   = 5,
    parameter int SYNC_STAGES   = 2
) (
    input  logic                clk_i,
    input  logic                rst_i,
    inout  wire  [NUM_PINS-1:0] pin_io,
    open_drain_loopback_tester_if.slave ctl
);

    localparam int TW = talker_width(NUM_PINS);
    localparam int CW = cnt_width(PULSE_COUNT);

    localparam logic [31:0]   T_LAST      = 32'(TICK_INTERVAL - 1);
    localparam logic [31:0]   H_LAST      = 32'(TICK_INTERVAL / 2 - 1);
    localparam logic [CW-1:0] P_LAST      = CW'(PULSE_COUNT - 1);
    localparam logic [CW-1:0] P_TARGET    = CW'(PULSE_COUNT);
    localparam logic [TW-1:0] LAST_TALKER = TW'(NUM_PINS - 1);

    // The released half-period must outlast the synchroniser plus edge detect.
    if (TICK_INTERVAL / 2 <= SYNC_STAGES + 2) begin : g_bad_tick
        $error("TICK_INTERVAL/2 must exceed SYNC_STAGES+2");
    end

    state_e              state_q;
    logic [31:0]         tick_q;
    logic [CW-1:0]       period_q;
    logic [TW-1:0]       talker_q;
    logic [NUM_PINS-1:0] drive_q;
    logic                busy_q;
    logic                done_q;
    logic                idle_ok_q;
    logic [NUM_PINS-1:0] pass_q;

    logic [NUM_PINS-1:0] level;
    logic [CW-1:0]       count [NUM_PINS];
    logic                cnt_clr;
    logic                cnt_en;
    logic                counts_ok;

    assign cnt_clr = (state_q == IDLE) || (state_q == SETTLE) || (state_q == NEXT);
    assign cnt_en  = (state_q == TALK) || (state_q == TAIL);

    for (genvar i = 0; i < NUM_PINS; i++) begin : g_pin
        open_drain_loopback_tester_pin_channel #(
            .SYNC_STAGES(SYNC_STAGES),
            .PULSE_COUNT(PULSE_COUNT),
            .CW         (CW)
        ) u_chan (
            .clk_i      (clk_i),
            .rst_i      (rst_i),
            .drive_low_i(drive_q[i]),
            .clr_i      (cnt_clr),
            .cnt_en_i   (cnt_en),
            .pad_io     (pin_io[i]),
            .level_o    (level[i]),
            .count_o    (count[i])
        );
    end

    // Every pin, talker included, must have seen exactly PULSE_COUNT releases.
    always_comb begin
        counts_ok = 1'b1;
        for (int i = 0; i < NUM_PINS; i++) begin
            if (count[i] != P_TARGET) counts_ok = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            tick_q    <= '0;
            period_q  <= '0;
            talker_q  <= '0;
            drive_q   <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            idle_ok_q <= 1'b0;
            pass_q    <= '0;
        end else begin
            tick_q <= tick_q + 32'd1;
            unique case (state_q)
                IDLE: begin
                    tick_q <= '0;
                    if (ctl.start_i) begin
                        done_q   <= 1'b0;
                        pass_q   <= '0;
                        talker_q <= '0;
                        busy_q   <= 1'b1;
                        state_q  <= SETTLE;
                    end
                end
                SETTLE: begin
                    if (tick_q == T_LAST) begin
                        idle_ok_q <= &level;
                        period_q  <= '0;
                        tick_q    <= '0;
                        state_q   <= TALK;
                    end
                end
                TALK: begin
                    // drive_q is registered, so it is set one tick early to pull
                    // the net low exactly on ticks T/2..T-1.
                    if (tick_q == H_LAST) drive_q[talker_q] <= 1'b1;
                    if (tick_q == T_LAST) begin
                        drive_q  <= '0;
                        tick_q   <= '0;
                        period_q <= period_q + CW'(1);
                        if (period_q == P_LAST) state_q <= TAIL;
                    end
                end
                TAIL: begin
                    if (tick_q == H_LAST) begin
                        tick_q  <= '0;
                        state_q <= CHECK;
                    end
                end
                CHECK: begin
                    pass_q[talker_q] <= idle_ok_q & counts_ok;
                    tick_q           <= '0;
                    state_q          <= NEXT;
                end
                NEXT: begin
                    tick_q <= '0;
                    if (talker_q == LAST_TALKER) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= IDLE;
                    end else begin
                        talker_q <= talker_q + TW'(1);
                        state_q  <= SETTLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign ctl.busy_o      = busy_q;
    assign ctl.done_o      = done_q;
    assign ctl.talker_o    = talker_q;
    assign ctl.pass_mask_o = pass_q;
    assign ctl.led_recv_o  = level;
    assign ctl.state_o     = state_q;

endmodule

// File: tb/tb_open_drain_loopback_tester.sv
// Bench for the loopback tester: three pulled-up pins whose wiring, stuck lines and
// glitches are chosen per run, checked against a phase-timing reference model.
module tb_open_drain_loopback_tester;
    import open_drain_loopback_tester_pkg::*;

    localparam int N     = 3;
    localparam int T     = 8;
    localparam int P     = 3;
    localparam int S     = 2;
    localparam int H     = T / 2;
    localparam int PHASE = T + P * T + H + 2;
    localparam int RUN   = N * PHASE;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    wire  [N-1:0] pins;
    logic [N-1:0] tb_low  = '0;
    logic [N-1:0] ext_low = '0;
    int           grp [N];
    int           errors = 0;
    int           checks = 0;
    logic [N-1:0] exp_q [$];
    logic         prev_done = 1'b0;
    logic [N-1:0] last_mask = '0;

    open_drain_loopback_tester_if #(.NUM_PINS(N)) ctl ();

    open_drain_loopback_tester #(
        .NUM_PINS     (N),
        .TICK_INTERVAL(T),
        .PULSE_COUNT  (P),
        .SYNC_STAGES  (S)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .pin_io(pins),
        .ctl   (ctl)
    );

    // ---------------- clock / physical net ----------------
    always #5 clk = ~clk;

    for (genvar i = 0; i < N; i++) begin : g_net
        assign pins[i] = tb_low[i] ? 1'b0 : 1'bz;
        pullup pu (pins[i]);
    end

    // Pins sharing a group id are one wire: a low seen on one is copied to the rest.
    task automatic net_update();
        logic [N-1:0] dut_low;
        logic [N-1:0] nxt;
        for (int k = 0; k < N; k++) dut_low[k] = (pins[k] == 1'b0) && !tb_low[k];
        for (int j = 0; j < N; j++) begin
            nxt[j] = ext_low[j];
            for (int k = 0; k < N; k++) begin
                if (k != j && grp[k] == grp[j] && (dut_low[k] || ext_low[k])) nxt[j] = 1'b1;
            end
        end
        tb_low = nxt;
    endtask

    always @(posedge clk) begin
        #1;
        net_update();
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic set_ext(input logic [N-1:0] m);
        ext_low = m;
        net_update();
    endtask

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Net level n cycles after the accepted start: the talker of phase n/PHASE pulls
    // its group low in the second half of each TALK period; external lows pull theirs.
    function automatic logic [N-1:0] exp_pins(input int n);
        logic [N-1:0] lvl;
        int           t;
        int           o;
        logic         driving;
        t       = n / PHASE;
        o       = n % PHASE;
        driving = (n < RUN) && (o >= T) && (o < T + P * T) && (((o - T) % T) >= H);
        for (int k = 0; k < N; k++) begin
            lvl[k] = 1'b1;
            if (driving && grp[k] == grp[t]) lvl[k] = 1'b0;
            for (int m = 0; m < N; m++) begin
                if (ext_low[m] && grp[m] == grp[k]) lvl[k] = 1'b0;
            end
        end
        return lvl;
    endfunction

    function automatic logic [N-1:0] idle_levels(input logic [N-1:0] stuck);
        logic [N-1:0] lvl;
        for (int k = 0; k < N; k++) begin
            lvl[k] = 1'b1;
            for (int m = 0; m < N; m++) begin
                if (stuck[m] && grp[m] == grp[k]) lvl[k] = 1'b0;
            end
        end
        return lvl;
    endfunction

    // A phase passes only when every pin shares the talker's wire, no line is
    // stuck low and no extra edge was injected during that phase.
    function automatic logic [N-1:0] exp_mask(input logic [N-1:0] stuck, input int glitch_t);
        logic         all_short;
        logic [N-1:0] m;
        all_short = 1'b1;
        for (int k = 0; k < N; k++) if (grp[k] != grp[0]) all_short = 1'b0;
        for (int t = 0; t < N; t++) m[t] = all_short && (stuck == '0) && (glitch_t != t);
        return m;
    endfunction

    // ---------------- scenario tasks ----------------
    task automatic run_case(input logic [N-1:0] stuck, input int glitch_t, input int restart_n);
        logic [N-1:0] lvl;
        logic [N-1:0] gmask;
        int           base;
        exp_q.push_back(exp_mask(stuck, glitch_t));
        lvl = idle_levels(stuck);
        set_ext(stuck);
        repeat (4) step();
        check_eq("led_idle", 32'(ctl.led_recv_o), 32'(lvl));
        check_eq("done_hold", 32'(ctl.done_o), 32'(prev_done));
        if (prev_done) check_eq("mask_hold", 32'(ctl.pass_mask_o), 32'(last_mask));

        ctl.start_i = 1'b1;
        step();
        ctl.start_i = 1'b0;
        check_eq("busy_start", 32'(ctl.busy_o), 32'd1);
        check_eq("done_clr", 32'(ctl.done_o), 32'd0);
        check_eq("mask_clr", 32'(ctl.pass_mask_o), 32'd0);
        check_eq("state_start", 32'(ctl.state_o), 32'(SETTLE));
        check_eq("pins_n0", 32'(pins), 32'(exp_pins(0)));

        gmask = '0;
        if (glitch_t >= 0) gmask[glitch_t] = 1'b1;
        base = glitch_t * PHASE + 2 * T;
        for (int n = 1; n <= RUN; n++) begin
            step();
            check_eq("pins", 32'(pins), 32'(exp_pins(n)));
            if (n < RUN && (n % PHASE) == 0) begin
                check_eq("talker", 32'(ctl.talker_o), 32'(n / PHASE));
                check_eq("busy_run", 32'(ctl.busy_o), 32'd1);
            end
            if (n == RUN - 1) check_eq("done_early", 32'(ctl.done_o), 32'd0);
            if (n == RUN) begin
                check_eq("done_end", 32'(ctl.done_o), 32'd1);
                check_eq("busy_end", 32'(ctl.busy_o), 32'd0);
                check_eq("pass_mask", 32'(ctl.pass_mask_o), 32'(exp_q.pop_front()));
                check_eq("led_end", 32'(ctl.led_recv_o), 32'(lvl));
            end
            ctl.start_i = (n == restart_n);
            if (glitch_t >= 0 && n == base + 1) set_ext(stuck | gmask);
            if (glitch_t >= 0 && n == base + 3) set_ext(stuck);
        end
        ctl.start_i = 1'b0;
        set_ext('0);
        prev_done = 1'b1;
        last_mask = exp_mask(stuck, glitch_t);
        repeat (2) step();
    endtask

    task automatic run_reset();
        for (int k = 0; k < N; k++) grp[k] = 0;
        set_ext('0);
        repeat (2) step();
        ctl.start_i = 1'b1;
        step();
        ctl.start_i = 1'b0;
        for (int n = 1; n <= 12; n++) step();
        check_eq("pins_pre_rst", 32'(pins), 32'd0);
        rst = 1'b1;
        step();
        check_eq("pins_rst", 32'(pins), 32'({N{1'b1}}));
        check_eq("busy_rst", 32'(ctl.busy_o), 32'd0);
        check_eq("done_rst", 32'(ctl.done_o), 32'd0);
        check_eq("mask_rst", 32'(ctl.pass_mask_o), 32'd0);
        check_eq("talker_rst", 32'(ctl.talker_o), 32'd0);
        rst = 1'b0;
        prev_done = 1'b0;
        step();
    endtask

    // ---------------- main sequence and report ----------------
    initial begin
        logic [N-1:0] stuck;
        int           sel;
        int           gl;
        int           rs;
        ctl.start_i = 1'b0;
        for (int k = 0; k < N; k++) grp[k] = 0;
        repeat (3) step();
        check_eq("busy_init", 32'(ctl.busy_o), 32'd0);
        check_eq("done_init", 32'(ctl.done_o), 32'd0);
        check_eq("mask_init", 32'(ctl.pass_mask_o), 32'd0);
        check_eq("talker_init", 32'(ctl.talker_o), 32'd0);
        check_eq("state_init", 32'(ctl.state_o), 32'(IDLE));
        check_eq("pins_init", 32'(pins), 32'({N{1'b1}}));
        rst = 1'b0;
        step();

        // all shorted, then pin 2 on its own pull-up
        run_case('0, -1, -1);
        grp[0] = 0; grp[1] = 0; grp[2] = 1;
        run_case('0, -1, -1);
        // net held low, then an extra pulse during talker 1
        for (int k = 0; k < N; k++) grp[k] = 0;
        run_case(3'b001, -1, -1);
        run_case('0, 1, -1);
        // reset while driving, fresh run, ignored restart, back-to-back rerun
        run_reset();
        run_case('0, -1, -1);
        run_case('0, -1, 60);
        run_case('0, -1, -1);

        for (int r = 0; r < 6; r++) begin
            sel = $urandom_range(0, 2);
            for (int k = 0; k < N; k++) begin
                if (sel == 0) grp[k] = 0;
                else if (sel == 1) grp[k] = $urandom_range(0, 1);
                else grp[k] = k;
            end
            stuck = '0;
            if ($urandom_range(0, 3) == 0) stuck[$urandom_range(0, N - 1)] = 1'b1;
            gl = -1;
            if (stuck == '0 && $urandom_range(0, 2) == 0) gl = $urandom_range(0, N - 1);
            rs = -1;
            if ($urandom_range(0, 1) == 1) rs = $urandom_range(2, RUN - 3);
            run_case(stuck, gl, rs);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/open_drain_loopback_tester.md
Name: open_drain_loopback_tester

Overview:
Hardware-in-the-loop exerciser for N open-drain GPIO pins that are physically wired together on a common pulled-up net. Each pin in turn acts as talker. The talker pulses the net low a fixed number of times while every pin, including the talker, counts the released (rising) edges. The result is a per-talker pass mask, which shows that RTL tristate logic and .cst open-drain configuration are both correct before the I2C core is deployed.

Parameters:
NUM_PINS, 2, number of open-drain pins under test (2..8).
TICK_INTERVAL, 27000000, clocks per pulse period; first half released, second half driven low.
PULSE_COUNT, 5, low pulses issued per talker phase (1..15).
SYNC_STAGES, 2, synchroniser flops on each pin input (>=2).

Ports:
clk_i  input  1  system clock.
rst_i  input  1  synchronous, active-high reset.
start_i  input  1  single-cycle pulse that starts a full test run; ignored while busy_o=1.
pin_io  inout  NUM_PINS  open-drain pads; each bit is driven 0 or high-Z only, never 1.
led_recv_o  output  NUM_PINS  synchronised level of each pin.
busy_o  output  1  high from the cycle after an accepted start until done.
done_o  output  1  level; set at end of run, cleared by the next accepted start or by reset.
talker_o  output  max(1,$clog2(NUM_PINS))  index of the current talker.
pass_mask_o  output  NUM_PINS  bit t=1 when talker t's phase passed; valid while done_o=1.

Behaviour:
- Reset (sync, takes effect at the clock edge where rst_i=1):
  - all pin_io released (Z).
  - busy_o=0, done_o=0, talker_o=0, pass_mask_o=0.
  - all counters cleared, state=IDLE.
  - Reset mid-run releases a driven-low pin at that same edge; no partial result is kept.
- Per-pin path:
  - pad feeds SYNC_STAGES flops; led_recv_o = last stage.
  - rising edge = sync level 1 while the previous sync level was 0.
  - rising-edge counter per pin, width $clog2(PULSE_COUNT+2), saturates at PULSE_COUNT+1.
- FSM (tick counter 32-bit, cleared at every state entry):
  - IDLE: on start_i, clear done_o and pass_mask_o, set talker=0, go to SETTLE. busy_o=1 from the next cycle.
  - SETTLE: all pins released for TICK_INTERVAL cycles; edge counters held at 0. On the last cycle, latch idle_ok = AND of all sync levels (1 = no stuck-low line), then go to TALK.
  - TALK: PULSE_COUNT periods. Within each period, tick 0..T/2-1 releases the talker pin; tick T/2..T-1 drives it low. On period end, release the pin and increment the period count. After PULSE_COUNT periods go to TAIL.
  - TAIL: all released for T/2 cycles, so the final edge propagates through the synchroniser, then go to CHECK.
  - CHECK (1 cycle): pass_mask_o[talker] = idle_ok AND (every pin count == PULSE_COUNT, talker's own count included). Go to NEXT.
  - NEXT (1 cycle): clear edge counters. If talker==NUM_PINS-1, go to IDLE with busy_o=0 and done_o=1. Otherwise increment talker and go to SETTLE.
- Phase length per talker is exactly T + PULSE_COUNT*T + T/2 + 2 cycles (T/2 = floor).
- Only the talker pin is ever driven; all non-talker pins are Z in every state.
- A count above PULSE_COUNT (glitch or foreign driver) fails that phase. A count below PULSE_COUNT (open wire, pin not driving) fails as well.
- Elaboration check: TICK_INTERVAL/2 > SYNC_STAGES+2, else $error.

Decomposition:
- Header od_test_pkg.vh holds:
  - FSM state localparams: IDLE, SETTLE, TALK, TAIL, CHECK, NEXT.
  - the counter width function.
- Sub-module od_pin_channel is instanced NUM_PINS times. It contains:
  - tristate driver: drive_low_i to 0, otherwise Z.
  - synchroniser.
  - edge detector.
  - saturating counter, with clr_i and cnt_en_i.
  - outputs: level_o, count_o.
- Top module holds the FSM, tick/period counters and result latching.

Test Plan (bench: NUM_PINS=3, TICK_INTERVAL=8, PULSE_COUNT=3, SYNC_STAGES=2; wired-AND net with pullup):
1. All three pins shorted, start_i pulse:
   - each talker pulls the net low 3x for 4 cycles.
   - each phase is 8+24+4+2=38 cycles, giving done_o=1 after 114 cycles.
   - pass_mask_o=3'b111 and talker_o stepped 0,1,2.
2. Pin 2 left on its own pullup, pins 0/1 shorted:
   - pin 2 counts 0 in phases 0/1; pins 0/1 count 0 in phase 2.
   - pass_mask_o=3'b000.
3. Net held low externally throughout -> idle_ok=0 in every phase, pass_mask_o=3'b000, done_o still asserts.
4. Extra 3-cycle low glitch injected during talker 1's TALK -> counts reach 4 (saturate) -> pass_mask_o=3'b101.
5. rst_i asserted while talker 0 is driving low:
   - after that edge the pin is Z and busy_o=0, done_o=0, pass_mask_o=0.
   - a fresh start_i then completes with 3'b111.
6. start_i re-pulsed mid-run -> ignored, and the result matches scenario 1. start_i after done -> done_o and pass_mask_o clear next cycle, and the run repeats.
